iir_biquad_tdm: RTL and testbench
=================================

Name: iir_biquad_tdm

Overview:
- Time-multiplexed second-order (biquad) IIR filter, direct form I, shared by N_CH independent channels.
- Uses a single serial multiply-accumulate (MAC) engine.
- Coefficients can be loaded at run time; output saturation is optional.
- Successor to the fixed single-channel first-order IIR stage; sits in the simulator signal chain between the sample source and downstream shaping/accumulation.

Parameters:
- BITS_IN, 16, signed input sample width
- OUT_BITS, 24, signed output/feedback-state width
- COEF_BITS, 16, signed coefficient width
- FRAC_BITS, 10, coefficient fractional bits (post-sum arithmetic right shift)
- N_CH, 4, channel count (>=1); CH_W = max(1, clog2(N_CH))
- B0, 256, reset value of b0
- B1, 0, reset value of b1
- B2, 0, reset value of b2
- A1, -768, reset value of a1
- A2, 0, reset value of a2

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  sample offered
- in_ready  out  1  block can accept a sample
- in_ch  in  CH_W  channel of offered sample
- in_data  in  BITS_IN  signed sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5..7 ignored
- coef_data  in  COEF_BITS  signed coefficient value
- out_valid  out  1  one-cycle result strobe
- out_ch  out  CH_W  channel of result
- out_data  out  OUT_BITS  signed result

Behaviour:

Reset:
- One clock with reset high forces:
  - FSM to IDLE
  - in_ready=0 while reset is high
  - out_valid=0, out_ch=0, out_data=0
  - all per-channel history (x1, x2, y1, y2) to 0
  - coefficients to B0..A2
- Reset during MAC/WRITE aborts the sample: no output, history cleared.

Equation:
- y = (b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2) >>> FRAC_BITS
- The shift is arithmetic (floor).
- Accumulator width is BITS_IN+COEF_BITS+4 for x products and OUT_BITS+COEF_BITS+4 for y products; use the larger of the two. No intermediate truncation.
- The result is reduced to OUT_BITS per the optional feature below. That reduced value is what is output and stored as y1.

FSM states:
- IDLE:
  - in_ready=1.
  - in_valid=1 on an edge latches x and ch, then goes to MAC with tap=0.
  - If in_ch >= N_CH, the sample is consumed and dropped: stays in IDLE, no output, no state change.
- MAC:
  - Five cycles, tap 0..4: acc += coef[tap]*operand[tap].
  - Tap 0 clears acc to its product.
  - Operands are x, x1[ch], x2[ch], y1[ch], y2[ch]; a1 and a2 products are subtracted.
  - in_ready=0.
- WRITE:
  - One cycle: shift, reduce.
  - Register out_data and out_ch; set out_valid=1 for the next cycle.
  - Update x2<=x1, x1<=x, y2<=y1, y1<=y for ch only.
  - Return to IDLE.

Timing:
- Sample accepted at edge k: out_valid is high for exactly the cycle following edge k+6.
- in_ready is high again in that same cycle.
- Max throughput is 1 sample per 7 clocks. No output backpressure.
- out_data and out_ch hold their value after the out_valid pulse until the next result.

Coefficient writes:
- Honoured only in IDLE; coef_we while busy is dropped.
- coef_we and in_valid on the same IDLE edge: the coefficient is written and that sample uses the new value.
- Other channels' history is unaffected by writes.

Optional Feature:
- Macro: IIR_BIQUAD_SAT_EN.
- Defined: the shifted sum saturates to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1]. Additional output port sat_flag (out, 1) pulses with out_valid when clamping occurred.
- Undefined: the sum is truncated to its low OUT_BITS bits (two's-complement wrap). sat_flag does not exist.

Test Plan:
1. Impulse, defaults, ch0: x=1024 then x=0 three times -> out_data 256, 192, 144, 108; out_valid 7 clocks after each accept.
2. Step, defaults, ch1: x=1000 twice -> 250, then 437 (448000>>>10). ch0 history untouched; next ch0 zero input -> 0.
3. Interleave ch0 impulse 1024 with ch2 step 1000, alternating, 4 samples each -> ch0 gives 256, 192, 144, 108; ch2 gives 250, 437, 577, 682. out_ch matches.
4. Load B0=32767, A1=-1024 via coef port, then x=32767 repeated 9 times:
   - outputs 1048512·n for n=1..8 (n=8 gives 8388096)
   - 9th output: 8388607 with sat_flag=1 (macro on), or -7340608 (macro off)
5. coef_we asserted during MAC -> ignored (next sample uses old value). coef_addr=6 -> no change. in_ch=N_CH on a non-power-of-2 build (N_CH=3) -> no out_valid, in_ready stays 1.
6. Reset asserted at the 3rd MAC cycle -> no out_valid. After release, in_ready=1; impulse 1024 -> 256 (history and coefficients back to defaults).

Source files
------------

// File: rtl/iir_biquad_tdm.sv
// iir_biquad_tdm: N_CH-channel time-multiplexed direct-form-I biquad sharing one serial MAC.
// Latency: sample accepted at edge k -> out_valid in the cycle after edge k+6 (1 sample per 7 clocks).
// Backpressure: in_ready low while busy; no output backpressure. Macro IIR_BIQUAD_SAT_EN adds saturation + sat_flag.
module iir_biquad_tdm #(
   parameter int BITS_IN   = 16,
   parameter int OUT_BITS  = 24,
   parameter int COEF_BITS = 16,
   parameter int FRAC_BITS = 10,
   parameter int N_CH      = 4,
   parameter int B0        = 256,
   parameter int B1        = 0,
   parameter int B2        = 0,
   parameter int A1        = -768,
   parameter int A2        = 0,
   localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CH_W-1:0]      in_ch,
   input  logic [BITS_IN-1:0]   in_data,
   input  logic                 coef_we,
   input  logic [2:0]           coef_addr,
   input  logic [COEF_BITS-1:0] coef_data,
   output logic                 out_valid,
   output logic [CH_W-1:0]      out_ch,
   output logic [OUT_BITS-1:0]  out_data
`ifdef IIR_BIQUAD_SAT_EN
   ,
   output logic                 sat_flag
`endif
);

   // Accumulator wide enough for either product family plus 4 bits of sum growth.
   localparam int XAW = BITS_IN + COEF_BITS + 4;
   localparam int YAW = OUT_BITS + COEF_BITS + 4;
   localparam int AW  = (XAW > YAW) ? XAW : YAW;
   localparam int OPW = (BITS_IN > OUT_BITS) ? BITS_IN : OUT_BITS;
   localparam int PW  = COEF_BITS + OPW;

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE} state_t;

   state_t                      state;
   logic [2:0]                  tap;
   logic signed [BITS_IN-1:0]   x_q;
   logic [CH_W-1:0]             ch_q;
   logic signed [AW-1:0]        acc;
   logic signed [COEF_BITS-1:0] b0, b1, b2, a1, a2;
   logic signed [BITS_IN-1:0]   x1 [N_CH];
   logic signed [BITS_IN-1:0]   x2 [N_CH];
   logic signed [OUT_BITS-1:0]  y1 [N_CH];
   logic signed [OUT_BITS-1:0]  y2 [N_CH];

   logic signed [COEF_BITS-1:0] mul_coef;
   logic signed [OPW-1:0]       mul_opnd;
   logic signed [PW-1:0]        prod;
   logic signed [AW-1:0]        prod_ext;
   logic signed [AW-1:0]        acc_nxt;
   logic signed [OUT_BITS-1:0]  y_red;

   assign in_ready = (state == S_IDLE) && !reset;

   // Tap-indexed operand mux and one MAC step; feedback taps (3,4) subtract.
   always_comb begin
      mul_coef = b0;
      mul_opnd = OPW'(x_q);
      case (tap)
         3'd1:    begin mul_coef = b1; mul_opnd = OPW'(x1[ch_q]); end
         3'd2:    begin mul_coef = b2; mul_opnd = OPW'(x2[ch_q]); end
         3'd3:    begin mul_coef = a1; mul_opnd = OPW'(y1[ch_q]); end
         3'd4:    begin mul_coef = a2; mul_opnd = OPW'(y2[ch_q]); end
         default: ;
      endcase
      prod     = PW'(mul_coef) * PW'(mul_opnd);
      prod_ext = AW'(prod);
      if (tap == 3'd0)
         acc_nxt = prod_ext;
      else if (tap >= 3'd3)
         acc_nxt = acc - prod_ext;
      else
         acc_nxt = acc + prod_ext;
   end

`ifdef IIR_BIQUAD_SAT_EN
   localparam logic signed [AW-1:0] YMAX = {{(AW-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
   localparam logic signed [AW-1:0] YMIN = {{(AW-OUT_BITS+1){1'b1}}, {(OUT_BITS-1){1'b0}}};
   logic signed [AW-1:0] shifted;
   logic                 clip;

   // Floor-shift the sum and clamp it into the output range.
   always_comb begin
      shifted = acc >>> FRAC_BITS;
      clip    = 1'b1;
      if (shifted > YMAX)
         y_red = YMAX[OUT_BITS-1:0];
      else if (shifted < YMIN)
         y_red = YMIN[OUT_BITS-1:0];
      else begin
         y_red = shifted[OUT_BITS-1:0];
         clip  = 1'b0;
      end
   end
`else
   // Floor-shift the sum and wrap it to the output width.
   always_comb y_red = OUT_BITS'(acc >>> FRAC_BITS);
`endif

   // Sequencer: accept/drop in IDLE, five MAC taps, then write result and rotate channel history.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= S_IDLE;
         tap       <= 3'd0;
         x_q       <= '0;
         ch_q      <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_ch    <= '0;
         out_data  <= '0;
`ifdef IIR_BIQUAD_SAT_EN
         sat_flag  <= 1'b0;
`endif
         b0 <= COEF_BITS'(B0);
         b1 <= COEF_BITS'(B1);
         b2 <= COEF_BITS'(B2);
         a1 <= COEF_BITS'(A1);
         a2 <= COEF_BITS'(A2);
         for (int i = 0; i < N_CH; i++) begin
            x1[i] <= '0;
            x2[i] <= '0;
            y1[i] <= '0;
            y2[i] <= '0;
         end
      end else begin
         out_valid <= 1'b0;
`ifdef IIR_BIQUAD_SAT_EN
         sat_flag  <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               // Coefficient lands on the same edge as an accepted sample, so that sample sees it.
               if (coef_we) begin
                  case (coef_addr)
                     3'd0:    b0 <= coef_data;
                     3'd1:    b1 <= coef_data;
                     3'd2:    b2 <= coef_data;
                     3'd3:    a1 <= coef_data;
                     3'd4:    a2 <= coef_data;
                     default: ;
                  endcase
               end
               // Out-of-range channels are consumed and dropped without leaving IDLE.
               if (in_valid && (int'(in_ch) < N_CH)) begin
                  x_q   <= in_data;
                  ch_q  <= in_ch;
                  tap   <= 3'd0;
                  state <= S_MAC;
               end
            end
            S_MAC: begin
               acc <= acc_nxt;
               if (tap == 3'd4)
                  state <= S_WRITE;
               else
                  tap <= tap + 3'd1;
            end
            S_WRITE: begin
               out_valid  <= 1'b1;
               out_ch     <= ch_q;
               out_data   <= y_red;
`ifdef IIR_BIQUAD_SAT_EN
               sat_flag   <= clip;
`endif
               x2[ch_q]   <= x1[ch_q];
               x1[ch_q]   <= x_q;
               y2[ch_q]   <= y1[ch_q];
               y1[ch_q]   <= y_red;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iir_biquad_tdm.sv
// tb_iir_biquad_tdm: directed tests for iir_biquad_tdm with hand-computed expected outputs.
// A second instance with N_CH=3 exercises out-of-range channel dropping.
// Build with +define+IIR_BIQUAD_SAT_EN to check the saturating variant.
module tb_iir_biquad_tdm;

   logic        clock     = 1'b0;
   logic        reset     = 1'b1;
   logic        in_valid  = 1'b0;
   logic [1:0]  in_ch     = '0;
   logic [15:0] in_data   = '0;
   logic        coef_we   = 1'b0;
   logic [2:0]  coef_addr = '0;
   logic [15:0] coef_data = '0;
   logic        in_ready, out_valid;
   logic [1:0]  out_ch;
   logic [23:0] out_data;

   logic        s_in_valid  = 1'b0;
   logic [1:0]  s_in_ch     = '0;
   logic [15:0] s_in_data   = '0;
   logic        s_coef_we   = 1'b0;
   logic [2:0]  s_coef_addr = '0;
   logic [15:0] s_coef_data = '0;
   logic        s_in_ready, s_out_valid;
   logic [1:0]  s_out_ch;
   logic [23:0] s_out_data;

`ifdef IIR_BIQUAD_SAT_EN
   logic sat_flag, s_sat_flag, last_sat;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   iir_biquad_tdm dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data)
`ifdef IIR_BIQUAD_SAT_EN
      , .sat_flag(sat_flag)
`endif
   );

   iir_biquad_tdm #(.N_CH(3)) dut3 (
      .clock(clock), .reset(reset),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_ch(s_in_ch), .in_data(s_in_data),
      .coef_we(s_coef_we), .coef_addr(s_coef_addr), .coef_data(s_coef_data),
      .out_valid(s_out_valid), .out_ch(s_out_ch), .out_data(s_out_data)
`ifdef IIR_BIQUAD_SAT_EN
      , .sat_flag(s_sat_flag)
`endif
   );

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      coef_we  = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   task automatic wr_coef(input logic [2:0] a, input logic [15:0] d);
      coef_we = 1'b1; coef_addr = a; coef_data = d;
      @(posedge clock); #1;
      coef_we = 1'b0;
   endtask

   // Offer one sample, optionally strobe a b0 write during the first MAC cycle, wait for the result.
   task automatic send(input logic [1:0] ch, input logic [15:0] d, input bit mac_wr,
                       output logic [23:0] y, output logic [1:0] och, output int lat);
      int w;
      w = 0;
      while (in_ready !== 1'b1 && w < 20) begin
         @(posedge clock); #1;
         w++;
      end
      in_valid = 1'b1; in_ch = ch; in_data = d;
      @(posedge clock); #1;
      in_valid = 1'b0;
      if (mac_wr) begin
         coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'd512;
      end
      lat = -1; y = '0; och = '0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clock); #1;
         coef_we = 1'b0;
         if (out_valid === 1'b1) begin
            lat = i; y = out_data; och = out_ch;
`ifdef IIR_BIQUAD_SAT_EN
            last_sat = sat_flag;
`endif
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(posedge clock); #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_out_ch: got %0d want 0", out_ch); end
      checks++; if (out_data !== 24'd0) begin errors++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
      reset = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_impulse();
      logic [23:0] y; logic [1:0] c; int lat;
      int exp_y [4];
      exp_y = '{256, 192, 144, 108};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send(2'd0, (i == 0) ? 16'd1024 : 16'd0, 1'b0, y, c, lat);
         checks++; if (y !== 24'(exp_y[i])) begin errors++; $display("FAIL impulse_data[%0d]: got %0d want %0d", i, $signed(y), exp_y[i]); end
         checks++; if (c !== 2'd0) begin errors++; $display("FAIL impulse_ch[%0d]: got %0d want 0", i, c); end
         checks++; if (lat != 6) begin errors++; $display("FAIL impulse_latency[%0d]: got %0d want 6", i, lat); end
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL impulse_ready[%0d]: got %b want 1", i, in_ready); end
      end
      @(posedge clock); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pulse_width: got %b want 0", out_valid); end
      checks++; if (out_data !== 24'd108) begin errors++; $display("FAIL out_hold: got %0d want 108", out_data); end
   endtask

   task automatic test_step();
      logic [23:0] y; logic [1:0] c; int lat;
      do_reset();
      send(2'd1, 16'd1000, 1'b0, y, c, lat);
      checks++; if (y !== 24'd250) begin errors++; $display("FAIL step_0: got %0d want 250", $signed(y)); end
      checks++; if (c !== 2'd1) begin errors++; $display("FAIL step_0_ch: got %0d want 1", c); end
      send(2'd1, 16'd1000, 1'b0, y, c, lat);
      checks++; if (y !== 24'd437) begin errors++; $display("FAIL step_1: got %0d want 437", $signed(y)); end
      send(2'd0, 16'd0, 1'b0, y, c, lat);
      checks++; if (y !== 24'd0) begin errors++; $display("FAIL step_ch0_isolated: got %0d want 0", $signed(y)); end
      checks++; if (c !== 2'd0) begin errors++; $display("FAIL step_ch0_ch: got %0d want 0", c); end
   endtask

   task automatic test_interleave();
      logic [23:0] y; logic [1:0] c; int lat;
      int imp [4];
      int stp [4];
      imp = '{256, 192, 144, 108};
      stp = '{250, 437, 577, 682};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send(2'd0, (i == 0) ? 16'd1024 : 16'd0, 1'b0, y, c, lat);
         checks++; if (y !== 24'(imp[i]) || c !== 2'd0) begin errors++; $display("FAIL ileave_ch0[%0d]: got %0d ch%0d want %0d ch0", i, $signed(y), c, imp[i]); end
         send(2'd2, 16'd1000, 1'b0, y, c, lat);
         checks++; if (y !== 24'(stp[i]) || c !== 2'd2) begin errors++; $display("FAIL ileave_ch2[%0d]: got %0d ch%0d want %0d ch2", i, $signed(y), c, stp[i]); end
      end
   endtask

   task automatic test_saturation();
      logic [23:0] y; logic [1:0] c; int lat;
      logic [23:0] e;
      do_reset();
      wr_coef(3'd0, 16'h7FFF);
      wr_coef(3'd3, 16'hFC00);
      for (int n = 1; n <= 9; n++) begin
         send(2'd3, 16'h7FFF, 1'b0, y, c, lat);
`ifdef IIR_BIQUAD_SAT_EN
         e = (n == 9) ? 24'h7FFFFF : 24'(1048512 * n);
         checks++; if (last_sat !== (n == 9)) begin errors++; $display("FAIL sat_flag[%0d]: got %b want %b", n, last_sat, (n == 9)); end
`else
         e = (n == 9) ? 24'(-7340608) : 24'(1048512 * n);
`endif
         checks++; if (y !== e) begin errors++; $display("FAIL accum[%0d]: got %0d want %0d", n, $signed(y), $signed(e)); end
      end
   endtask

   task automatic test_ignored_writes();
      logic [23:0] y; logic [1:0] c; int lat;
      bit seen_valid, seen_busy;
      int exp3 [3];
      exp3 = '{256, 192, 144};
      do_reset();
      send(2'd0, 16'd1024, 1'b1, y, c, lat);
      checks++; if (y !== 24'd256) begin errors++; $display("FAIL busy_write_same: got %0d want 256", $signed(y)); end
      send(2'd1, 16'd1024, 1'b0, y, c, lat);
      checks++; if (y !== 24'd256) begin errors++; $display("FAIL busy_write_next: got %0d want 256", $signed(y)); end
      wr_coef(3'd5, 16'h1234);
      wr_coef(3'd6, 16'h1234);
      wr_coef(3'd7, 16'h1234);
      for (int i = 0; i < 3; i++) begin
         send(2'd2, (i == 0) ? 16'd1024 : 16'd0, 1'b0, y, c, lat);
         checks++; if (y !== 24'(exp3[i])) begin errors++; $display("FAIL bad_addr[%0d]: got %0d want %0d", i, $signed(y), exp3[i]); end
      end
      // N_CH=3 instance: channel 3 is out of range and must be dropped.
      s_in_valid = 1'b1; s_in_ch = 2'd3; s_in_data = 16'd1024;
      @(posedge clock); #1;
      s_in_valid = 1'b0;
      seen_valid = 1'b0; seen_busy = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (s_out_valid !== 1'b0) seen_valid = 1'b1;
         if (s_in_ready !== 1'b1) seen_busy = 1'b1;
         @(posedge clock); #1;
      end
      checks++; if (seen_valid) begin errors++; $display("FAIL drop_no_output: got out_valid=1 want 0"); end
      checks++; if (seen_busy) begin errors++; $display("FAIL drop_ready: got in_ready=0 want 1"); end
      s_in_valid = 1'b1; s_in_ch = 2'd2; s_in_data = 16'd1024;
      @(posedge clock); #1;
      s_in_valid = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clock); #1;
         if (s_out_valid === 1'b1) begin lat = i; break; end
      end
      checks++; if (lat != 6 || s_out_data !== 24'd256 || s_out_ch !== 2'd2) begin errors++; $display("FAIL n3_ch2: got lat=%0d data=%0d ch=%0d want 6/256/2", lat, $signed(s_out_data), s_out_ch); end
`ifdef IIR_BIQUAD_SAT_EN
      checks++; if (s_sat_flag !== 1'b0) begin errors++; $display("FAIL n3_sat: got %b want 0", s_sat_flag); end
`endif
   endtask

   task automatic test_reset_abort();
      logic [23:0] y; logic [1:0] c; int lat;
      bit seen_valid;
      do_reset();
      wr_coef(3'd0, 16'd512);
      send(2'd0, 16'd1024, 1'b0, y, c, lat);
      checks++; if (y !== 24'd512) begin errors++; $display("FAIL pre_abort: got %0d want 512", $signed(y)); end
      in_valid = 1'b1; in_ch = 2'd0; in_data = 16'd1024;
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      seen_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid !== 1'b0) seen_valid = 1'b1;
         @(posedge clock); #1;
      end
      checks++; if (seen_valid) begin errors++; $display("FAIL abort_no_output: got out_valid=1 want 0"); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", in_ready); end
      send(2'd0, 16'd1024, 1'b0, y, c, lat);
      checks++; if (y !== 24'd256) begin errors++; $display("FAIL post_abort: got %0d want 256", $signed(y)); end
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_step();
      test_interleave();
      test_saturation();
      test_ignored_writes();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
